// File: rtl/rf_pkg.sv
// rf_pkg: shared opcode and sequencer state enums for rf_seq.
package rf_pkg;
  typedef enum logic [1:0] {OP_LDI = 2'b00, OP_MOV = 2'b01, OP_ADD = 2'b10, OP_NOP = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR} state_e;
endpackage

// File: rtl/rf_seq.sv
// rf_seq: command sequencer driving a single-port register file (LDI/MOV/ADD/NOP).
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready handshake with cmd_op,
// cmd_dst, cmd_src, cmd_imm; rf_adr/rf_ce/rf_data_in drive the register file,
// rf_data_out is its combinational read data; done pulses on completion; carry
// holds the carry of the last ADD.
// Build option: RF_SEQ_ADD_EN enables the ADD path and carry; without it ADD acts as NOP.
module rf_seq
  import rf_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] rf_data_in,
  output logic          rf_ce,
  output logic [AW-1:0] rf_adr,
  input  logic [DW-1:0] rf_data_out,
  output logic          done,
  output logic          carry
);
`ifdef RF_SEQ_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif
  state_e        r_state;
  op_e           r_op;
  logic [AW-1:0] r_dst, r_src;
  logic [DW-1:0] r_imm, r_a;
  logic          r_done;
  logic [DW-1:0] w_res;
  op_e           w_op;
  logic          w_rd;
  assign w_op = op_e'(cmd_op);
  // MOV always reads its source; ADD only does when the ADD path is built
  assign w_rd = w_op == OP_MOV || (ADD_EN && w_op == OP_ADD);
  assign cmd_ready = r_state == IDLE && !rst;
  assign rf_ce = r_state == WR;
  assign rf_adr = r_state == RD_A ? r_src : r_state == IDLE ? '0 : r_dst;
  assign rf_data_in = rf_ce ? w_res : '0;
  assign done = r_done;
`ifdef RF_SEQ_ADD_EN
  logic [DW-1:0] r_b;
  logic          r_carry;
  logic [DW:0]   w_sum;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_res = r_op == OP_ADD ? w_sum[DW-1:0] : r_op == OP_MOV ? r_a : r_imm;
  assign carry = r_carry;
`else
  assign w_res = r_op == OP_MOV ? r_a : r_imm;
  assign carry = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_dst   <= '0;
      r_src   <= '0;
      r_imm   <= '0;
      r_a     <= '0;
      r_done  <= 1'b0;
`ifdef RF_SEQ_ADD_EN
      r_b     <= '0;
      r_carry <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op    <= w_op;
          r_dst   <= cmd_dst;
          r_src   <= cmd_src;
          r_imm   <= cmd_imm;
          r_state <= w_op == OP_LDI ? WR : w_rd ? RD_A : IDLE;
          r_done  <= !w_rd;
        end
        RD_A: begin
          r_a     <= rf_data_out;
          r_state <= r_op == OP_MOV ? WR : RD_B;
          r_done  <= r_op == OP_MOV;
        end
`ifdef RF_SEQ_ADD_EN
        RD_B: begin
          r_b     <= rf_data_out;
          r_state <= WR;
          r_done  <= 1'b1;
        end
        WR: begin
          r_carry <= r_op == OP_ADD ? w_sum[DW] : r_carry;
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq: directed, table-driven bench for rf_seq with a behavioural 8x8 register file.
module tb_rf_seq;
`ifdef RF_SEQ_ADD_EN
  localparam bit ADD = 1'b1;
`else
  localparam bit ADD = 1'b0;
`endif
  logic       clk, rst, cmd_valid, cmd_ready, rf_ce, done, carry;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst, cmd_src, rf_adr;
  logic [7:0] cmd_imm, rf_data_in, rf_data_out;
  logic [7:0] rf [8] = '{default: 8'd0};
  int checks = 0, failures = 0;

  rf_seq #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rf_data_in(rf_data_in), .rf_ce(rf_ce), .rf_adr(rf_adr),
    .rf_data_out(rf_data_out), .done(done), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rf_data_out = rf[rf_adr];
  always @(posedge clk) if (rf_ce) rf[rf_adr] <= rf_data_in;

  typedef struct {
    logic [1:0] op;
    int dst, src, imm, lat, nce, adr1, wadr, wdat, cy;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", int'(cmd_ready), 1);
  endtask

  task automatic issue(input logic [1:0] op, input int dst, input int src, input int imm,
                       output int lat, output int nce, output int adr1, output int wadr, output int wdat);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_dst = 3'(dst);
    cmd_src = 3'(src);
    cmd_imm = 8'(imm);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = -1; nce = 0; adr1 = -1; wadr = -1; wdat = -1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) adr1 = int'(rf_adr);
      if (rf_ce) begin
        nce++;
        wadr = int'(rf_adr);
        wdat = int'(rf_data_in);
      end
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat, nce, adr1, wadr, wdat, p;
    tbl[0] = '{2'd0, 2, 0, 6,   1, 1, 2, 2, 6,   0};
    tbl[1] = '{2'd1, 5, 2, 0,   2, 1, 2, 5, 6,   0};
    tbl[2] = '{2'd0, 1, 0, 200, 1, 1, 1, 1, 200, 0};
    tbl[3] = '{2'd0, 3, 0, 100, 1, 1, 3, 3, 100, 0};
    tbl[4] = '{2'd3, 1, 2, 0,   1, 0, 0, 0, 0,   0};
    tbl[5] = '{2'd0, 7, 0, 255, 1, 1, 7, 7, 255, 0};
    tbl[6] = '{2'd1, 0, 7, 0,   2, 1, 7, 0, 255, 0};
`ifdef RF_SEQ_ADD_EN
    tbl[7] = '{2'd2, 2, 2, 0,   3, 1, 2, 2, 12,  0};
    tbl[8] = '{2'd2, 3, 1, 0,   3, 1, 1, 3, 44,  1};
    tbl[9] = '{2'd1, 4, 4, 0,   2, 1, 4, 4, 0,   1};
`else
    tbl[7] = '{2'd2, 2, 2, 0,   1, 0, 0, 0, 0,   0};
    tbl[8] = '{2'd2, 3, 1, 0,   1, 0, 0, 0, 0,   0};
    tbl[9] = '{2'd1, 4, 4, 0,   2, 1, 4, 4, 0,   0};
`endif
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd3; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", int'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_ce", int'(rf_ce), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_adr", int'(rf_adr), 0);
    chk("rst_wdata", int'(rf_data_in), 0);
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, lat, nce, adr1, wadr, wdat);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_ce_count", i), nce, tbl[i].nce);
      chk($sformatf("v%0d_first_adr", i), adr1, tbl[i].adr1);
      if (tbl[i].nce > 0) begin
        chk($sformatf("v%0d_wr_adr", i), wadr, tbl[i].wadr);
        chk($sformatf("v%0d_wr_data", i), wdat, tbl[i].wdat);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_carry", i), int'(carry), tbl[i].cy);
    end
    // cmd_valid held high: ready only in IDLE, one acceptance per command
    p = ADD ? 4 : 3;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = ADD ? 2'd2 : 2'd1;
    cmd_dst = ADD ? 3'd4 : 3'd6;
    cmd_src = ADD ? 3'd0 : 3'd5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("held_ready_%0d", i), int'(cmd_ready), int'(i % p == 0));
      chk($sformatf("held_done_%0d", i), int'(done), int'(i % p == p - 1));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
`ifdef RF_SEQ_ADD_EN
    chk("held_carry", int'(carry), 1);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_dst = 3'd3; cmd_src = 3'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("abort_rda_adr", int'(rf_adr), 1);
    @(posedge clk);
    #1;
    chk("abort_rdb_adr", int'(rf_adr), 3);
    chk("abort_rdb_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rst_ready", int'(cmd_ready), 0);
    chk("abort_ce", int'(rf_ce), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_carry", int'(carry), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_post_ce", int'(rf_ce), 0);
    chk("abort_post_done", int'(done), 0);
    chk("abort_post_ready", int'(cmd_ready), 1);
    chk("abort_r3", int'(rf[3]), 44);
`endif
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 3'd6; cmd_src = 3'd7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("mabort_rda_adr", int'(rf_adr), 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mabort_ce", int'(rf_ce), 0);
    chk("mabort_done", int'(done), 0);
    chk("mabort_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mabort_post_ce", int'(rf_ce), 0);
    chk("mabort_post_done", int'(done), 0);
    chk("mabort_carry", int'(carry), 0);
    chk("mabort_r6", int'(rf[6]), ADD ? 0 : 6);
    chk("final_r0", int'(rf[0]), 255);
    chk("final_r2", int'(rf[2]), ADD ? 12 : 6);
    chk("final_r3", int'(rf[3]), ADD ? 44 : 100);
    chk("final_r4", int'(rf[4]), ADD ? 254 : 0);
    chk("final_r5", int'(rf[5]), 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
